// File: rtl/demux_latch_259.sv
// Addressable 8-bit latch (74LS259-style) with an auto-scan mode that
// reassembles an LSB-first serial stream into bytes and flags each frame.
module demux_latch_259 (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic       c,
    input  logic       a,
    input  logic [2:0] s,
    input  logic       d,
    output logic [7:0] q,
    output logic       v,
    output logic [2:0] cnt
);

    localparam int unsigned W_Q   = 8;
    localparam int unsigned W_CNT = 3;
    localparam int unsigned W_SH  = 7;

    logic [W_Q-1:0]   r_q;
    logic [W_SH-1:0]  r_shadow;
    logic [W_CNT-1:0] r_cnt;
    logic             r_v;

    logic [W_Q-1:0]   w_q_nxt;
    logic [W_SH-1:0]  w_shadow_nxt;
    logic [W_CNT-1:0] w_cnt_nxt;
    logic             w_v_nxt;
    logic [W_Q-1:0]   w_sel_mask;
    logic [W_Q-1:0]   w_sel_data;

    // Decoded one-hot select and the data bit placed at that position
    assign w_sel_mask = W_Q'(1) << s;
    assign w_sel_data = W_Q'(d) << s;

    // Next-state selection for both addressed and auto-scan modes
    always_comb begin
        w_q_nxt      = r_q;
        w_shadow_nxt = r_shadow;
        w_cnt_nxt    = r_cnt;
        w_v_nxt      = 1'b0;
        if (!a) begin
            // Addressed mode: any partial auto frame is discarded
            w_cnt_nxt    = '0;
            w_shadow_nxt = '0;
            case ({e, c})
                2'b01:   w_q_nxt = (r_q & ~w_sel_mask) | w_sel_data;
                2'b00:   w_q_nxt = w_sel_data;
                2'b10:   w_q_nxt = '0;
                default: w_q_nxt = r_q;
            endcase
        end else if (!c) begin
            w_q_nxt      = '0;
            w_cnt_nxt    = '0;
            w_shadow_nxt = '0;
        end else if (!e) begin
            if (r_cnt == W_CNT'(7)) begin
                // Last bit of the frame completes the word on this same edge
                w_q_nxt      = {d, r_shadow};
                w_cnt_nxt    = '0;
                w_shadow_nxt = '0;
                w_v_nxt      = 1'b1;
            end else begin
                for (int i = 0; i < int'(W_SH); i++) begin
                    if (r_cnt == W_CNT'(i)) begin
                        w_shadow_nxt[i] = d;
                    end
                end
                w_cnt_nxt = r_cnt + W_CNT'(1);
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= '0;
            r_shadow <= '0;
            r_cnt    <= '0;
            r_v      <= 1'b0;
        end else begin
            r_q      <= w_q_nxt;
            r_shadow <= w_shadow_nxt;
            r_cnt    <= w_cnt_nxt;
            r_v      <= w_v_nxt;
        end
    end

    assign q   = r_q;
    assign v   = r_v;
    assign cnt = r_cnt;

endmodule

// File: tb/tb_demux_latch_259.sv
// Directed self-checking bench for demux_latch_259.
module tb_demux_latch_259;

    logic       clk;
    logic       rst;
    logic       e;
    logic       c;
    logic       a;
    logic [2:0] s;
    logic       d;
    logic [7:0] q;
    logic       v;
    logic [2:0] cnt;

    int n_cmp;
    int n_fail;

    demux_latch_259 dut (
        .clk (clk),
        .rst (rst),
        .e   (e),
        .c   (c),
        .a   (a),
        .s   (s),
        .d   (d),
        .q   (q),
        .v   (v),
        .cnt (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e = 1'($urandom); c = 1'($urandom); a = 1'($urandom);
            s = 3'($urandom); d = 1'($urandom);
            tick();
        end
        n_cmp++;
        if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q got=%h exp=00", q); end
        n_cmp++;
        if (v !== 1'b0) begin n_fail++; $display("FAIL reset_v got=%b exp=0", v); end
        n_cmp++;
        if (cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        rst = 1'b0;
    endtask

    task automatic test_addressed();
        a = 1'b0; e = 1'b0; c = 1'b1;
        s = 3'd3; d = 1'b1; tick();
        n_cmp++;
        if (q !== 8'h08) begin n_fail++; $display("FAIL addr_s3 got=%h exp=08", q); end
        s = 3'd5; d = 1'b1; tick();
        n_cmp++;
        if (q !== 8'h28) begin n_fail++; $display("FAIL addr_s5 got=%h exp=28", q); end
        e = 1'b1; s = 3'd0; d = 1'b1; tick();
        n_cmp++;
        if (q !== 8'h28) begin n_fail++; $display("FAIL addr_hold got=%h exp=28", q); end
        n_cmp++;
        if (v !== 1'b0 || cnt !== 3'd0) begin
            n_fail++; $display("FAIL addr_vcnt got v=%b cnt=%0d exp v=0 cnt=0", v, cnt);
        end
        e = 1'b0; s = 3'd5; d = 1'b0; tick();
        n_cmp++;
        if (q !== 8'h08) begin n_fail++; $display("FAIL addr_clrbit got=%h exp=08", q); end
    endtask

    task automatic test_demux_clear();
        a = 1'b0; e = 1'b0; c = 1'b0;
        s = 3'd6; d = 1'b1; tick();
        n_cmp++;
        if (q !== 8'h40) begin n_fail++; $display("FAIL demux_s6 got=%h exp=40", q); end
        d = 1'b0; tick();
        n_cmp++;
        if (q !== 8'h00) begin n_fail++; $display("FAIL demux_d0 got=%h exp=00", q); end
        c = 1'b1; s = 3'd2; d = 1'b1; tick();
        e = 1'b1; c = 1'b0; tick();
        n_cmp++;
        if (q !== 8'h00) begin n_fail++; $display("FAIL clear got=%h exp=00", q); end
    endtask

    task automatic test_auto_frame();
        logic [7:0] fr;
        fr = 8'h4D;
        // preload a recognisable value to show q holds mid-frame
        a = 1'b0; e = 1'b0; c = 1'b1; s = 3'd0; d = 1'b1; tick();
        s = 3'd7; tick();
        a = 1'b1; e = 1'b0; c = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = fr[i]; s = 3'($urandom);
            tick();
            if (i < 7) begin
                n_cmp++;
                if (q !== 8'h81 || v !== 1'b0 || cnt !== 3'(i + 1)) begin
                    n_fail++;
                    $display("FAIL auto_mid%0d got q=%h v=%b cnt=%0d exp q=81 v=0 cnt=%0d",
                             i, q, v, cnt, i + 1);
                end
            end
        end
        n_cmp++;
        if (q !== 8'h4D || v !== 1'b1 || cnt !== 3'd0) begin
            n_fail++; $display("FAIL auto_done got q=%h v=%b cnt=%0d exp q=4d v=1 cnt=0", q, v, cnt);
        end
        e = 1'b1; tick();
        n_cmp++;
        if (v !== 1'b0 || q !== 8'h4D) begin
            n_fail++; $display("FAIL auto_vpulse got v=%b q=%h exp v=0 q=4d", v, q);
        end
    endtask

    task automatic test_auto_stall();
        logic [7:0] fr;
        int pulses;
        fr = 8'h4D; pulses = 0;
        a = 1'b1; c = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 5) begin
                e = 1'b1; d = ~fr[4];
            end else begin
                e = 1'b0; d = fr[(i > 5) ? i - 2 : i];
            end
            tick();
            if (v === 1'b1) pulses++;
            if (i == 4 || i == 5) begin
                n_cmp++;
                if (cnt !== 3'd4) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=4", cnt); end
            end
        end
        n_cmp++;
        if (q !== 8'h4D || v !== 1'b1 || pulses != 1) begin
            n_fail++; $display("FAIL stall_done got q=%h v=%b pulses=%0d exp q=4d v=1 pulses=1", q, v, pulses);
        end
    endtask

    task automatic test_abort(input logic use_rst);
        logic [7:0] fr;
        int pulses;
        fr = 8'h0F; pulses = 0;
        a = 1'b1; e = 1'b0; c = 1'b1;
        for (int i = 0; i < 4; i++) begin d = 1'b1 ^ 1'(i); tick(); end
        if (use_rst) rst = 1'b1; else c = 1'b0;
        tick();
        n_cmp++;
        if (q !== 8'h00 || cnt !== 3'd0 || v !== 1'b0) begin
            n_fail++; $display("FAIL abort_clr rst=%b got q=%h cnt=%0d v=%b exp 00/0/0", use_rst, q, cnt, v);
        end
        rst = 1'b0; c = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = fr[i]; tick();
            if (v === 1'b1) pulses++;
        end
        n_cmp++;
        if (q !== 8'h0F || v !== 1'b1 || pulses != 1) begin
            n_fail++; $display("FAIL abort_frame rst=%b got q=%h v=%b pulses=%0d exp 0f/1/1", use_rst, q, v, pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] st;
        st = 16'h3CA5;
        a = 1'b1; e = 1'b0; c = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d = st[i]; tick();
            n_cmp++;
            if (v !== ((i == 7 || i == 15) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL b2b_v%0d got=%b", i, v);
            end
            if (i == 7) begin
                n_cmp++;
                if (q !== 8'hA5) begin n_fail++; $display("FAIL b2b_q1 got=%h exp=a5", q); end
            end
        end
        n_cmp++;
        if (q !== 8'h3C) begin n_fail++; $display("FAIL b2b_q2 got=%h exp=3c", q); end
    endtask

    task automatic test_mode_switch();
        logic [7:0] fr;
        fr = 8'h96;
        a = 1'b1; e = 1'b0; c = 1'b1;
        for (int i = 0; i < 3; i++) begin d = 1'b1; tick(); end
        a = 1'b0; e = 1'b1; c = 1'b1; tick();
        n_cmp++;
        if (q !== 8'h3C || cnt !== 3'd0 || v !== 1'b0) begin
            n_fail++; $display("FAIL switch_addr got q=%h cnt=%0d v=%b exp 3c/0/0", q, cnt, v);
        end
        a = 1'b1; e = 1'b0;
        for (int i = 0; i < 8; i++) begin d = fr[i]; s = 3'($urandom); tick(); end
        n_cmp++;
        if (q !== 8'h96 || v !== 1'b1) begin
            n_fail++; $display("FAIL switch_frame got q=%h v=%b exp 96/1", q, v);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; e = 1'b1; c = 1'b1; a = 1'b0; s = 3'd0; d = 1'b0;
        test_reset();
        test_addressed();
        test_demux_clear();
        test_auto_frame();
        test_auto_stall();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        test_mode_switch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
